mf_seq_ctrl: RTL and testbench

// - Sequencer for the 1-bit complex matched-filter datapath (four-way mf_1bit_512 array).
// - Accepts 1-bit I/Q samples over valid/ready and drives en/x_re/x_im into the filter.
// - Discards the partial-correlation warm-up outputs, then searches a fixed window of

---
 rtl/mf_ctrl_pkg.sv | 29 ++
 rtl/mf_seq_ctrl_if.sv | 27 ++
 rtl/mf_seq_ctrl_peak.sv | 39 +++
 rtl/mf_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_mf_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mf_ctrl_pkg.sv
// Shared types, widths and the |re|+|im| magnitude helper for the matched-filter sequencer.
package mf_ctrl_pkg;

  localparam int DW    = 32;
  localparam int MAG_W = DW + 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SEARCH,
    DRAIN,
    REPORT
  } mf_seq_state_t;

  // Operands are widened by one bit first so that |-2^(DW-1)| stays exact.
  function automatic logic [MAG_W-1:0] mag_abs_sum(input logic signed [DW-1:0] re,
                                                   input logic signed [DW-1:0] im);
    logic [MAG_W-1:0] re_x;
    logic [MAG_W-1:0] im_x;
    logic [MAG_W-1:0] re_a;
    logic [MAG_W-1:0] im_a;
    re_x = {re[DW-1], re};
    im_x = {im[DW-1], im};
    re_a = re[DW-1] ? (~re_x + MAG_W'(1)) : re_x;
    im_a = im[DW-1] ? (~im_x + MAG_W'(1)) : im_x;
    return re_a + im_a;
  endfunction

endpackage

// File: rtl/mf_seq_ctrl_if.sv
// Sample stream and filter-side bus of the sequencer. The slave modport is the sequencer;
// the master modport is the front end plus filter array.
interface mf_seq_ctrl_if;
  import mf_ctrl_pkg::*;

  logic                 s_valid;
  logic                 s_re;
  logic                 s_im;
  logic                 s_ready;
  logic                 mf_en;
  logic                 mf_x_re;
  logic                 mf_x_im;
  logic                 mf_valid;
  logic signed [DW-1:0] mf_y_re;
  logic signed [DW-1:0] mf_y_im;

  modport master (
    output s_valid, s_re, s_im, mf_valid, mf_y_re, mf_y_im,
    input  s_ready, mf_en, mf_x_re, mf_x_im
  );

  modport slave (
    input  s_valid, s_re, s_im, mf_valid, mf_y_re, mf_y_im,
    output s_ready, mf_en, mf_x_re, mf_x_im
  );

endinterface

// File: rtl/mf_seq_ctrl_peak.sv
// Peak tracker: keeps the earliest strictly-largest magnitude at or above threshold.
// Results are folded in at the clock edge that follows their mf_valid cycle.
module mf_peak_track
  import mf_ctrl_pkg::*;
#(
  parameter int IDXW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 upd_en,
  input  logic signed [DW-1:0] y_re,
  input  logic signed [DW-1:0] y_im,
  input  logic [IDXW-1:0]      idx,
  input  logic [MAG_W-1:0]     thresh,
  output logic                 found,
  output logic [IDXW-1:0]      best_idx,
  output logic [MAG_W-1:0]     best_mag
);

  logic [MAG_W-1:0] mag;
  logic             take;

  assign mag  = mag_abs_sum(y_re, y_im);
  assign take = upd_en && (mag >= thresh) && (!found || (mag > best_mag));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      found    <= 1'b0;
      best_idx <= '0;
      best_mag <= '0;
    end else if (take) begin
      found    <= 1'b1;
      best_idx <= idx;
      best_mag <= mag;
    end
  end

endmodule

// File: rtl/mf_seq_ctrl.sv
// Matched-filter sequencer: feeds samples to the filter, skips warm-up results, then reports
// the window peak. Build option MFSEQ_EARLY_STOP_EN reports on the first threshold hit.
//
// state  | meaning
// IDLE   | waiting for start; counters and tracker cleared
// FILL   | accepting samples, discarding TAPS-1 warm-up results
// SEARCH | accepting samples, tracking peak over the window
// DRAIN  | all samples sent, collecting the remaining window results
// REPORT | one-cycle det_valid with tracker contents
module mf_seq_ctrl
  import mf_ctrl_pkg::*;
#(
  parameter  int TAPS    = 512,
  parameter  int WIN_LEN = 1024,
  localparam int IDXW    = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [MAG_W-1:0] thresh,
  mf_seq_ctrl_if.slave     bus,
  output logic             busy,
  output logic             det_valid,
  output logic             det_found,
  output logic [IDXW-1:0]  det_idx,
  output logic [MAG_W-1:0] det_mag
);

  localparam int ACC_LIM = TAPS - 1 + WIN_LEN;
  localparam int ACCW    = $clog2(ACC_LIM + 1);
  localparam int RESW    = $clog2(((TAPS > WIN_LEN) ? TAPS : WIN_LEN) + 1);

  mf_seq_state_t    state_q, state_d;
  logic [ACCW-1:0]  acc_cnt;
  logic [RESW-1:0]  res_cnt;
  logic [MAG_W-1:0] thresh_q;
  logic             accept, acc_done;
  logic             res_fill, fill_last, res_win, win_last, early_hit;
  logic             trk_found;
  logic [IDXW-1:0]  trk_idx;
  logic [MAG_W-1:0] trk_mag;
  logic             det_found_q;
  logic [IDXW-1:0]  det_idx_q;
  logic [MAG_W-1:0] det_mag_q;

  assign acc_done  = (acc_cnt == ACCW'(ACC_LIM));
  assign res_fill  = bus.mf_valid && (state_q == FILL);
  assign fill_last = res_fill && (res_cnt == RESW'(TAPS - 2));
  assign res_win   = bus.mf_valid && ((state_q == SEARCH) || (state_q == DRAIN));
  assign win_last  = res_win && (res_cnt == RESW'(WIN_LEN - 1));

`ifdef MFSEQ_EARLY_STOP_EN
  assign early_hit = res_win && (mag_abs_sum(bus.mf_y_re, bus.mf_y_im) >= thresh_q);
`else
  assign early_hit = 1'b0;
`endif

  // early_hit closes the sample gate in the same cycle the hit is seen
  assign bus.s_ready = ((state_q == FILL) || (state_q == SEARCH)) && !acc_done && !early_hit;
  assign accept      = bus.s_valid && bus.s_ready;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (start) state_d = FILL;
      FILL:          if (fill_last) state_d = SEARCH;
      SEARCH, DRAIN: begin
        if (win_last || early_hit) state_d = REPORT;
        else if (acc_done)         state_d = DRAIN;
      end
      REPORT:        state_d = IDLE;
      default:       state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_cnt  <= '0;
      res_cnt  <= '0;
      thresh_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        acc_cnt <= '0;
        res_cnt <= '0;
        if (start) thresh_q <= thresh;
      end else begin
        if (accept) acc_cnt <= acc_cnt + ACCW'(1);
        if (fill_last)                res_cnt <= '0;
        else if (res_fill || res_win) res_cnt <= res_cnt + RESW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mf_en   <= 1'b0;
      bus.mf_x_re <= 1'b0;
      bus.mf_x_im <= 1'b0;
      det_found_q <= 1'b0;
      det_idx_q   <= '0;
      det_mag_q   <= '0;
    end else begin
      bus.mf_en <= accept;
      if (accept) begin
        bus.mf_x_re <= bus.s_re;
        bus.mf_x_im <= bus.s_im;
      end
      if (state_q == REPORT) begin
        det_found_q <= trk_found;
        det_idx_q   <= trk_idx;
        det_mag_q   <= trk_mag;
      end
    end
  end

  // The REPORT cycle shows the tracker live; the copies keep the record afterwards.
  assign det_valid = (state_q == REPORT);
  assign det_found = det_valid ? trk_found : det_found_q;
  assign det_idx   = det_valid ? trk_idx   : det_idx_q;
  assign det_mag   = det_valid ? trk_mag   : det_mag_q;

  mf_peak_track #(.IDXW(IDXW)) u_peak (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == IDLE),
    .upd_en   (res_win),
    .y_re     (bus.mf_y_re),
    .y_im     (bus.mf_y_im),
    .idx      (res_cnt[IDXW-1:0]),
    .thresh   (thresh_q),
    .found    (trk_found),
    .best_idx (trk_idx),
    .best_mag (trk_mag)
  );

endmodule

// File: tb/tb_mf_seq_ctrl.sv
// Bench for mf_seq_ctrl with TAPS=4, WIN_LEN=8 and a stub filter returning tabled results
// two cycles after each mf_en.
module tb_mf_seq_ctrl;

  localparam int TAPS    = 4;
  localparam int WIN_LEN = 8;
  localparam int ACC_LIM = TAPS - 1 + WIN_LEN;

  logic        clk, rst, start, abort;
  logic [32:0] thresh;
  logic        busy, det_valid, det_found;
  logic [2:0]  det_idx;
  logic [32:0] det_mag;

  mf_seq_ctrl_if bus ();

  mf_seq_ctrl #(.TAPS(TAPS), .WIN_LEN(WIN_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .thresh    (thresh),
    .bus       (bus),
    .busy      (busy),
    .det_valid (det_valid),
    .det_found (det_found),
    .det_idx   (det_idx),
    .det_mag   (det_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint res_re [16];
  longint res_im [16];
  bit     expect_det = 0;
  bit     exp_found;
  longint exp_idx, exp_mag;
  bit     chk_on = 0;
  int     n_acc = 0, n_en = 0, n_det = 0;
  longint last_found, last_idx, last_mag;
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected record straight from the window contents (results TAPS-1 .. TAPS-2+WIN_LEN).
  task automatic model(input longint th);
    longint m;
    exp_found = 0;
    exp_idx   = 0;
    exp_mag   = 0;
    for (int i = 0; i < WIN_LEN; i++) begin
      m = labs(res_re[TAPS-1+i]) + labs(res_im[TAPS-1+i]);
      if (m >= th && (!exp_found || m > exp_mag)) begin
        exp_found = 1;
        exp_mag   = m;
        exp_idx   = i;
`ifdef MFSEQ_EARLY_STOP_EN
        break;
`endif
      end
    end
  endtask

  // Stub filter: result k follows the k-th mf_en of the run by two cycles.
  bit d0 = 0, d1 = 0;
  int stub_k = 0;
  always @(negedge clk) begin
    if (start === 1'b1) stub_k = 0;
    bus.mf_valid = d1;
    if (d1) begin
      bus.mf_y_re = (stub_k < 16) ? res_re[stub_k][31:0] : 32'sd0;
      bus.mf_y_im = (stub_k < 16) ? res_im[stub_k][31:0] : 32'sd0;
      stub_k++;
    end
    d1 = d0;
    d0 = (bus.mf_en === 1'b1);
  end

  // Per-cycle compare against the sample queue, the accept cap and the expected record.
  always @(negedge clk) begin
    if (chk_on) begin
      if (bus.mf_en === 1'b1) begin
        n_en++;
        check("mf_en_has_sample", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("mf_x", {bus.mf_x_re, bus.mf_x_im}, exp_q.pop_front());
      end
      if (n_acc >= ACC_LIM) check("s_ready_cap", bus.s_ready, 0);
      if (det_valid === 1'b1) begin
        n_det++;
        check("det_expected", expect_det, 1);
        check("det_found", det_found, exp_found);
        check("det_idx", det_idx, exp_idx);
        check("det_mag", det_mag, exp_mag);
        last_found = det_found;
        last_idx   = det_idx;
        last_mag   = det_mag;
      end
      if (start === 1'b1) begin
        n_acc = 0;
        n_en  = 0;
        n_det = 0;
      end
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) begin
        exp_q.push_back({bus.s_re, bus.s_im});
        n_acc++;
      end
    end
  end

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) begin
      res_re[i] = 0;
      res_im[i] = 0;
    end
  endtask

  task automatic set_win(input int i, input longint re, input longint im);
    res_re[TAPS-1+i] = re;
    res_im[TAPS-1+i] = im;
  endtask

  task automatic run_test(input string name, input longint th, input bit toggle);
    model(th);
    expect_det = 1;
    thresh = th[32:0];
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    thresh = '0;
    for (int c = 0; c < 300 && n_det == 0; c++) begin
      bus.s_valid = toggle ? ~c[0] : 1'b1;
      bus.s_re    = 1'($urandom_range(0, 1));
      bus.s_im    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check({name, "_reports"}, n_det, 1);
`ifndef MFSEQ_EARLY_STOP_EN
    check({name, "_en_pulses"}, n_en, ACC_LIM);
`endif
    expect_det = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; thresh = '0;
    bus.s_valid = 1'b1; bus.s_re = 1'b0; bus.s_im = 1'b0;
    bus.mf_valid = 1'b0; bus.mf_y_re = '0; bus.mf_y_im = '0;
    clear_tab();
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_mf_en", bus.mf_en, 0);
    check("rst_det_valid", det_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_det_mag", det_mag, 0);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    chk_on = 1;
    repeat (2) @(posedge clk);
    #1;

    // Basic peak: mags 5,120,300,40,300,7,0,2 with thresh 100
    clear_tab();
    set_win(0, 5, 0);    set_win(1, -100, 20); set_win(2, 150, -150); set_win(3, 0, -40);
    set_win(4, -300, 0); set_win(5, 3, 4);     set_win(6, 0, 0);      set_win(7, -1, -1);
    run_test("basic", 100, 0);
`ifndef MFSEQ_EARLY_STOP_EN
    check("basic_lit_found", last_found, 1);
    check("basic_lit_idx", last_idx, 2);
    check("basic_lit_mag", last_mag, 300);
    check("basic_hold_mag", det_mag, 300);
`else
    check("basic_lit_idx", last_idx, 1);
    check("basic_lit_mag", last_mag, 120);
`endif

    // No detect: everything below 1000
    clear_tab();
    set_win(0, 500, 499); set_win(1, -999, 0); set_win(2, 300, -300); set_win(5, -1, 998);
    run_test("nodet", 1000, 0);
    check("nodet_lit_found", last_found, 0);
    check("nodet_lit_idx", last_idx, 0);
    check("nodet_lit_mag", last_mag, 0);

    // Back-pressure with alternating s_valid
    clear_tab();
    set_win(0, 10, 0);  set_win(1, 0, -60); set_win(2, -70, 5); set_win(3, 20, 20);
    set_win(5, -80, 0); set_win(6, 75, 0);  set_win(7, 1, 1);
    run_test("bp", 50, 1);
    check("bp_lit_found", last_found, 1);
`ifndef MFSEQ_EARLY_STOP_EN
    check("bp_lit_idx", last_idx, 5);
    check("bp_lit_mag", last_mag, 80);
`else
    check("bp_lit_idx", last_idx, 1);
`endif

    // Extremes: both parts at the most negative value
    clear_tab();
    set_win(0, -64'sd2147483648, -64'sd2147483648);
    run_test("ext", 64'd4294967296, 0);
    check("ext_lit_found", last_found, 1);
    check("ext_lit_idx", last_idx, 0);
    check("ext_lit_mag", last_mag, 64'd4294967296);

    // Abort mid-SEARCH with a simultaneous start; a report here would be flagged
    clear_tab();
    for (int i = 0; i < WIN_LEN; i++) set_win(i, 50, 50);
    expect_det = 0;
    thresh = 33'd10;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.s_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy_after", busy, 0);
    check("abort_s_ready_after", bus.s_ready, 0);
    check("abort_no_det", det_valid, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_s_ready", bus.s_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort2_busy", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_det_count", n_det, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
